ft_fifo_pipe: RTL and testbench

FT_FIFO_PIPE -- requirements
Module: ft_fifo_pipe

---
 rtl/ft_fifo_pkg.sv | 21 ++
 rtl/ft_fifo_pipe.sv | 159 +++++++++++++++
 tb/tb_ft_fifo_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_fifo_pkg.sv
// Shared sizing helpers for the fall-through FIFO pipe that sits behind a
// fixed-latency RAM FIFO.
package ft_fifo_pkg;

    // Skid depth: one entry per read that can be in flight, plus one entry
    // so that a pop and a refill can overlap every cycle.
    function automatic int depth_of(input int rd_lat);
        return rd_lat + 1;
    endfunction

    // Width of the occupancy counter; it must be able to hold 0..DEPTH.
    function automatic int count_w(input int rd_lat);
        return $clog2(rd_lat + 2);
    endfunction

    // Width of a skid pointer; it never drops below one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : ft_fifo_pkg

// File: rtl/ft_fifo_pipe.sv
// Fall-through FIFO stage behind a RAM FIFO with an RD_LAT-cycle read latency.
// Each read is tracked through a valid shift register. Returning data lands in a
// DEPTH-entry skid buffer, and the head of that buffer drives ft_data.
// ram_pop is only issued when the skid has room for every outstanding read,
// so a write into a full skid cannot happen.
module ft_fifo_pipe
    import ft_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 32,
    parameter int RD_LAT     = 2,
    parameter bit LESS_RST   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sync_rst_n,
    input  logic                          ram_fifo_empty,
    input  logic [FIFO_WIDTH-1:0]         ram_fifo_data,
    output logic                          ram_pop,
    input  logic                          ft_pop,
    output logic                          ft_valid,
    output logic [FIFO_WIDTH-1:0]         ft_data,
    output logic [count_w(RD_LAT)-1:0]    ft_count,
    output logic                          underflow_err
);

    localparam int DEPTH = depth_of(RD_LAT);
    localparam int CW    = count_w(RD_LAT);
    localparam int PW    = ptr_w(DEPTH);
    // One extra bit so that occupancy plus in-flight reads cannot wrap.
    localparam int SW    = CW + 1;

    // sr_q[0] is the final stage: its data is on ram_fifo_data this cycle.
    logic [RD_LAT-1:0]      sr_q, sr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic                   err_q, err_d;
    logic [FIFO_WIDTH-1:0]  mem_q [DEPTH];
    logic [FIFO_WIDTH-1:0]  mem_d [DEPTH];

    logic                   pop_fire;
    logic                   wr_en;
    logic [SW-1:0]          inflight;
    logic [SW-1:0]          occ;

    // The pointers wrap explicitly, so a DEPTH that is not a power of two works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ft_valid      = vld_q[rd_ptr_q];
    assign ft_data       = mem_q[rd_ptr_q];
    assign ft_count      = cnt_q;
    assign underflow_err = err_q;

    // Decide whether a RAM read can be issued this cycle.
    always_comb begin
        // NOTE: every variable gets a default value first, so that no path infers a latch.
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + SW'(sr_q[i]);
        end
        pop_fire = ft_valid && ft_pop;
        // A flush has priority over landing RAM data.
        wr_en    = sr_q[0] && sync_rst_n;
        // The read landing this cycle is not in cnt_q yet, so it still counts as in flight.
        occ      = SW'(cnt_q) + inflight - SW'(pop_fire);
        ram_pop  = rst_n && sync_rst_n && !ram_fifo_empty && (occ < SW'(DEPTH));
    end

    // Next state of the shift register, the pointers, the valid bits and the count.
    always_comb begin
        sr_d     = sr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        if (!sync_rst_n) begin
            sr_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            vld_d    = '0;
        end else begin
            for (int i = 0; i < RD_LAT - 1; i++) begin
                sr_d[i] = sr_q[i+1];
            end
            sr_d[RD_LAT-1] = ram_pop;
            if (pop_fire) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ptr_inc(rd_ptr_q);
            end
            if (wr_en) begin
                vld_d[wr_ptr_q] = 1'b1;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            cnt_d = cnt_q + CW'(wr_en) - CW'(pop_fire);
        end
        // This flag is sticky, and a flush does not clear it.
        err_d = err_q | (ft_pop & ~ft_valid);
    end

    // Next state of the skid storage: returning RAM data is written at the tail.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = ram_fifo_data;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so that every flop samples pre-edge values.
        if (!rst_n) begin
            sr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    generate
        if (LESS_RST) begin : g_mem_nrst
            // Data storage register without a reset; the valid bits guard every read.
            always_ff @(posedge clk) begin
                // NOTE: the data array has no reset here, because ft_data is only meaningful while ft_valid is set.
                mem_q <= mem_d;
            end
        end else begin : g_mem_rst
            // Data storage register that resets to zero, so ft_data reads 0 after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q <= '{default: '0};
                end else begin
                    mem_q <= mem_d;
                end
            end
        end
    endgenerate

    a_rd_lat_range: assert property (@(posedge clk) (RD_LAT >= 1) && (RD_LAT <= 4));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !pop_fire && (cnt_q == CW'(DEPTH))));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CW'(DEPTH));

endmodule : ft_fifo_pipe

// File: tb/tb_ft_fifo_pipe.sv
// Bench for ft_fifo_pipe. The main instance uses RD_LAT=3 (DEPTH=4). A second
// instance uses RD_LAT=1 and is used for the 1-word/cycle streaming case.
// A RAM model feeds each instance, and a scoreboard of RAM words holds the
// expected order of the outputs.
module tb_ft_fifo_pipe;

    localparam int W     = 32;
    localparam int RL    = 3;
    localparam int DEPTH = RL + 1;
    localparam int CW    = $clog2(RL + 2);
    localparam int NRAM  = 4096;

    logic          clk = 1'b0;
    logic          rst_n, sync_rst_n;
    logic          ram_fifo_empty, ram_pop;
    logic [W-1:0]  ram_fifo_data;
    logic          ft_pop, ft_valid, underflow_err;
    logic [W-1:0]  ft_data;
    logic [CW-1:0] ft_count;

    always #5 clk = ~clk;

    ft_fifo_pipe #(.FIFO_WIDTH(W), .RD_LAT(RL), .LESS_RST(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n),
        .ram_fifo_empty(ram_fifo_empty), .ram_fifo_data(ram_fifo_data), .ram_pop(ram_pop),
        .ft_pop(ft_pop), .ft_valid(ft_valid), .ft_data(ft_data),
        .ft_count(ft_count), .underflow_err(underflow_err)
    );

    // Second instance: RD_LAT=1, DEPTH=2.
    logic         d1_rst_n, d1_empty, d1_ram_pop, d1_valid, d1_err, d1_go;
    logic [W-1:0] d1_ram_data, d1_fdata;
    logic [1:0]   d1_count;
    logic         d1_pop = 1'b1;
    int           d1_idx = 0;

    ft_fifo_pipe #(.FIFO_WIDTH(W), .RD_LAT(1), .LESS_RST(1'b1)) u_dut1 (
        .clk(clk), .rst_n(d1_rst_n), .sync_rst_n(1'b1),
        .ram_fifo_empty(d1_empty), .ram_fifo_data(d1_ram_data), .ram_pop(d1_ram_pop),
        .ft_pop(d1_pop), .ft_valid(d1_valid), .ft_data(d1_fdata),
        .ft_count(d1_count), .underflow_err(d1_err)
    );

    assign d1_empty = !d1_go || (d1_idx >= 100);
    always @(posedge clk) begin
        d1_ram_data <= d1_ram_pop ? 32'(d1_idx) : $urandom;
        if (d1_ram_pop) d1_idx <= d1_idx + 1;
    end

    // RAM model: data appears RL cycles after the pop that requested it.
    logic [W-1:0] ram_words [NRAM];
    logic [W-1:0] ram_pipe  [RL];
    int           ram_n = 0;
    int           ram_rd_idx = 0;

    assign ram_fifo_empty = (ram_rd_idx >= ram_n);
    assign ram_fifo_data  = ram_pipe[0];

    always @(posedge clk) begin
        for (int i = 0; i < RL - 1; i++) ram_pipe[i] <= ram_pipe[i+1];
        ram_pipe[RL-1] <= ram_pop ? ram_words[ram_rd_idx] : $urandom;
        if (ram_pop) ram_rd_idx <= ram_rd_idx + 1;
    end

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. Each word popped from the RAM must come out once, in order,
    // unless a flush or reset intervenes. Popped-but-undelivered words never exceed DEPTH.
    logic [W-1:0] exp_q[$];
    int           outstanding = 0;
    int           accept_cnt  = 0;
    bit           prev_hold   = 0;
    logic [W-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            prev_hold   = 0;
        end else begin
            if (prev_hold) check("hold_stable", ft_data, prev_data);
            check("valid_vs_count", ft_valid, ft_count != 0);
            check("count_le_depth", ft_count <= CW'(DEPTH), 1);
            if (!sync_rst_n) begin
                check("flush_no_pop", ram_pop, 0);
                exp_q.delete();
                outstanding = 0;
            end else begin
                if (ft_valid && ft_pop) begin
                    accept_cnt++;
                    outstanding--;
                    check("output_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("data_order", ft_data, exp_q.pop_front());
                end
                if (ram_pop) begin
                    exp_q.push_back(ram_words[ram_rd_idx]);
                    outstanding++;
                end
                check("no_overflow", outstanding <= DEPTH, 1);
            end
            prev_hold = ft_valid && !ft_pop && sync_rst_n;
            prev_data = ft_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        ram_n = ram_n + n;
    endtask

    // Reset the DUT with the RAM empty. The task returns one time unit after a posedge.
    task automatic do_reset();
        rst_n      = 1'b0;
        ft_pop     = 1'b0;
        sync_rst_n = 1'b1;
        ram_n      = ram_rd_idx;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int n_words;
        int exp_pops;
        int exp_count;
        bit exp_valid;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pops, acc0, got, first_c, last_c, base;
        logic [W-1:0] first_w;
        logic [W-1:0] seen[$];

        tbl[0] = '{1, 1, 1, 1};
        tbl[1] = '{2, 2, 2, 1};
        tbl[2] = '{4, 4, 4, 1};
        tbl[3] = '{10, 4, 4, 1};
        tbl[4] = '{0, 0, 0, 0};
        tbl[5] = '{6, 4, 4, 1};

        for (int i = 0; i < NRAM; i++) ram_words[i] = $urandom;
        d1_rst_n = 1'b0;
        d1_go    = 1'b0;

        // Reset state, with the RAM not empty so that ram_pop is gated by reset.
        rst_n = 1'b0; sync_rst_n = 1'b1; ft_pop = 1'b0; ram_n = 1;
        @(negedge clk);
        check("rst_valid", ft_valid, 0);
        check("rst_count", ft_count, 0);
        check("rst_ram_pop", ram_pop, 0);
        check("rst_err", underflow_err, 0);
        check("rst_data", ft_data, 0);
        ram_n = 0;
        tick();
        rst_n = 1'b1;

        // Table-driven fill/backpressure then drain.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            first_w = ram_words[ram_n];
            load(tbl[v].n_words);
            pops = 0;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                if (ram_pop) pops++;
            end
            check($sformatf("tbl%0d_pops", v), pops, tbl[v].exp_pops);
            check($sformatf("tbl%0d_count", v), ft_count, tbl[v].exp_count);
            check($sformatf("tbl%0d_valid", v), ft_valid, tbl[v].exp_valid);
            if (tbl[v].n_words > 0) check($sformatf("tbl%0d_head", v), ft_data, first_w);
            tick();
            ft_pop = 1'b1;
            acc0 = accept_cnt;
            repeat (20) @(negedge clk);
            check($sformatf("tbl%0d_drained", v), accept_cnt - acc0, tbl[v].n_words);
        end

        // Single entry: exact latency from ram_pop to ft_valid.
        do_reset();
        ram_words[ram_n] = 32'hA5A5_0001;
        load(1);
        @(negedge clk);
        check("single_c0_pop", ram_pop, 1);
        for (int k = 1; k <= RL; k++) begin
            @(negedge clk);
            check($sformatf("single_c%0d_valid", k), ft_valid, 0);
        end
        @(negedge clk);
        check("single_c4_valid", ft_valid, 1);
        check("single_c4_data", ft_data, 32'hA5A5_0001);
        check("single_c4_count", ft_count, 1);

        // Streaming 0..99 with ft_pop held high.
        do_reset();
        for (int i = 0; i < 100; i++) ram_words[ram_n + i] = 32'(i);
        ft_pop = 1'b1;
        load(100);
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 300 && got < 100; c++) begin
            @(negedge clk);
            if (ft_valid && ft_pop) begin
                check("stream_value", ft_data, 32'(got));
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
        end
        check("stream_count", got, 100);
        check("stream_first_cycle", first_c, RL + 1);
        check("stream_no_gap", last_c - first_c, 99);

        // Flush with 2 words in the skid and 2 reads in flight.
        do_reset();
        base = ram_n;
        load(2);
        for (int c = 0; c < 20 && ft_count != 2; c++) @(negedge clk);
        check("flush_pre_count", ft_count, 2);
        tick();
        load(4);
        tick();
        tick();
        sync_rst_n = 1'b0;
        tick();
        sync_rst_n = 1'b1;
        @(negedge clk);
        check("flush_valid", ft_valid, 0);
        check("flush_count", ft_count, 0);
        tick();
        ft_pop = 1'b1;
        seen.delete();
        repeat (20) begin
            @(negedge clk);
            if (ft_valid && ft_pop) seen.push_back(ft_data);
        end
        check("flush_out_n", seen.size(), 2);
        if (seen.size() == 2) begin
            check("flush_out0", seen[0], ram_words[base + 4]);
            check("flush_out1", seen[1], ram_words[base + 5]);
        end

        // Underflow: the flag is sticky through a flush and cleared only by rst_n.
        do_reset();
        @(negedge clk);
        check("uf_initial", underflow_err, 0);
        tick();
        ft_pop = 1'b1;
        tick();
        ft_pop = 1'b0;
        @(negedge clk);
        check("uf_set", underflow_err, 1);
        check("uf_count", ft_count, 0);
        tick();
        sync_rst_n = 1'b0;
        tick();
        sync_rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("uf_held", underflow_err, 1);
        #2 rst_n = 1'b0;
        #1 check("uf_cleared", underflow_err, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a stream.
        do_reset();
        ft_pop = 1'b1;
        load(20);
        repeat (8) tick();
        @(negedge clk);
        check("areset_pre_valid", ft_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_valid", ft_valid, 0);
        check("areset_count", ft_count, 0);
        check("areset_ram_pop", ram_pop, 0);
        check("areset_data", ft_data, 0);
        ram_n = ram_rd_idx;
        repeat (2) tick();
        rst_n = 1'b1;

        // Random traffic, checked by the scoreboard.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick();
            ft_pop     = ($urandom_range(3) != 0);
            sync_rst_n = ($urandom_range(39) != 0);
            if ($urandom_range(3) == 0) load($urandom_range(3));
        end
        tick();
        ft_pop = 1'b1;
        sync_rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ram_fifo_empty && exp_q.size() == 0 && outstanding == 0) break;
        end
        check("random_drained", exp_q.size(), 0);

        // RD_LAT=1 instance: 1 word per cycle with DEPTH=2.
        tick();
        d1_rst_n = 1'b1;
        d1_go    = 1'b1;
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 300 && got < 100; c++) begin
            @(negedge clk);
            check("d1_count_le_depth", d1_count <= 2'd2, 1);
            if (d1_valid && d1_pop) begin
                check("d1_value", d1_fdata, 32'(got));
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
        end
        check("d1_count", got, 100);
        check("d1_no_gap", last_c - first_c, 99);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule : tb_ft_fifo_pipe
